// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage: main + skid register with valid/ready handshake and synchronous flush.
// Optional backpressure counter enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_skid #(
   parameter int unsigned            DATA_W    = 32,
   parameter logic [DATA_W-1:0]      RESET_VAL = '0,
   parameter int unsigned            CNT_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              out_valid_q, out_valid_d;
   logic              in_ready_q, in_ready_d;
   logic [1:0]        occ_q, occ_d;
   logic              in_fire;
   logic              out_fire;

   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = out_valid_q & out_ready;

   // Next state and data movement; handshake outputs are decoded from the next state
   // so they are flops that depend on state only.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (clear) begin
         state_d = EMPTY;
         main_d  = RESET_VAL;
         skid_d  = RESET_VAL;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  main_d  = in_data;
                  state_d = ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_d = in_data;
               end else if (in_fire) begin
                  skid_d  = in_data;
                  state_d = FULL;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (out_fire) begin
                  main_d  = skid_q;
                  state_d = ONE;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end

      out_valid_d = (state_d != EMPTY);
      in_ready_d  = (state_d != FULL);
      case (state_d)
         ONE:     occ_d = 2'd1;
         FULL:    occ_d = 2'd2;
         default: occ_d = 2'd0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= EMPTY;
         main_q      <= RESET_VAL;
         skid_q      <= RESET_VAL;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         occ_q       <= 2'd0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         occ_q       <= occ_d;
      end
   end

   assign out_valid = out_valid_q;
   assign in_ready  = in_ready_q;
   assign out_data  = main_q;
   assign occupancy = occ_q;

`ifdef PIPE_STAGE_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of cycles spent holding data the consumer refuses; clear does not touch it.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: stimulus pushes accepted beats, a negedge monitor pops on out_fire.
module tb_pipe_stage_skid;
   localparam int unsigned      DATA_W = 32;
   localparam int unsigned      CNT_W  = 4;
   localparam logic [31:0]      RST_V  = 32'h5A5A_0000;

   logic              clk = 1'b0;
   logic              reset;
   logic              clear;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        occupancy;
   logic [CNT_W-1:0]  stall_cnt;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];

   pipe_stage_skid #(.DATA_W(DATA_W), .RESET_VAL(RST_V), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One cycle of stimulus; a clear seen at this edge flushes the scoreboard after the monitor's last pop.
   task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic c);
      @(posedge clk);
      if (clear || reset) exp_q.delete();
      #1;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      clear     = c;
      if (v && in_ready && !c) exp_q.push_back(d);
   endtask

   // Monitor: the beat presented while out_valid & out_ready is consumed at the next edge.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", out_data, 32'hFFFF_FFFF);
         end else begin
            chk("beat_data", out_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready",  32'(in_ready), 32'd1);
      chk("rst_occ",       32'(occupancy), 32'd0);
      chk("rst_data",      out_data, RST_V);
      chk("rst_stall",     32'(stall_cnt), 32'd0);
      reset = 1'b0;

      // single beat, 1-cycle latency
      drive(1'b1, 32'h11, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_data",  out_data, 32'h11);
      chk("single_occ",   32'(occupancy), 32'd1);
      chk("single_ready", 32'(in_ready), 32'd1);
      drive(1'b0, 32'h0, 1'b1, 1'b0);

      // full-rate stream
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 32'(i), 1'b1, 1'b0);
         chk("stream_ready", 32'(in_ready), 32'd1);
         if (i > 1) chk("stream_valid", 32'(out_valid), 32'd1);
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("stream_last", out_data, 32'h8);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("stream_empty", 32'(out_valid), 32'd0);

      // backpressure into the skid register
      drive(1'b1, 32'hA, 1'b0, 1'b0);
      drive(1'b1, 32'hB, 1'b0, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      chk("bp_occ",   32'(occupancy), 32'd2);
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_data",  out_data, 32'hA);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      chk("bp_hold_data",  out_data, 32'hA);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("bp_ready_pop1", 32'(in_ready), 32'd0);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("bp_ready_pop2", 32'(in_ready), 32'd1);
      chk("bp_data2",      out_data, 32'hB);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("bp_drained", 32'(occupancy), 32'd0);

      // flush while FULL
      drive(1'b1, 32'hA, 1'b0, 1'b0);
      drive(1'b1, 32'hB, 1'b0, 1'b0);
      drive(1'b1, 32'hC, 1'b0, 1'b1);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("flush_occ",   32'(occupancy), 32'd0);
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_data",  out_data, RST_V);

      // flush in ONE: same-cycle out_fire consumed, same-cycle in_fire dropped
      drive(1'b1, 32'h21, 1'b0, 1'b0);
      drive(1'b1, 32'h22, 1'b1, 1'b1);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("flush1_valid", 32'(out_valid), 32'd0);
      chk("flush1_data",  out_data, RST_V);
      drive(1'b0, 32'h0, 1'b1, 1'b0);

      // sustained stall with one entry
      drive(1'b1, 32'h33, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) drive(1'b0, 32'h0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_STALL_CNT_EN
      chk("stall_sat", 32'(stall_cnt), 32'd15);
`else
      chk("stall_off", 32'(stall_cnt), 32'd0);
`endif
      chk("stall_data", out_data, 32'h33);
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_STALL_CNT_EN
      chk("stall_after_clear", 32'(stall_cnt), 32'd15);
`else
      chk("stall_after_clear", 32'(stall_cnt), 32'd0);
`endif

      // async reset mid-cycle while FULL
      drive(1'b1, 32'h44, 1'b0, 1'b0);
      drive(1'b1, 32'h55, 1'b0, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      chk("pre_rst_occ", 32'(occupancy), 32'd2);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_ready", 32'(in_ready), 32'd1);
      chk("arst_occ",   32'(occupancy), 32'd0);
      chk("arst_stall", 32'(stall_cnt), 32'd0);
      exp_q.delete();
      @(posedge clk);
      #1 reset = 1'b0;

      // recovery beat and drain
      drive(1'b1, 32'h66, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("recover_data", out_data, 32'h66);
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
